// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: 32-step restoring division, one-cycle HI/LO write pulse.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes in one cycle.
module div_unit (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        write_hilo_enable_o,
  output logic [31:0] write_hi_data_o,
  output logic [31:0] write_lo_data_o
);

`ifdef DIV_ZERO_FAST_EN
  localparam bit ZeroFastEn = 1'b1;
`else
  localparam bit ZeroFastEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, quo_nx;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    a_neg = signed_div_i & dividend_i[31];
    b_neg = signed_div_i & divisor_i[31];
    a_mag = a_neg ? -dividend_i : dividend_i;
    b_mag = b_neg ? -divisor_i : divisor_i;

    // One restoring step: remainder never exceeds the divisor, so 32 bits hold it.
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_nx = {quo_q[30:0], ~diff[32]};

    unique case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvsr_d    = b_mag;
          quo_d     = a_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (ZeroFastEn && (divisor_i == '0)) begin
            state_d = StDone;
            hi_d    = dividend_i;
            lo_d    = a_neg ? 32'd1 : '1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          hi_d    = neg_rem_q ? -rem_nx : rem_nx;
          lo_d    = neg_quo_q ? -quo_nx : quo_nx;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flush leaves the previously written result untouched.
    if (cancel_i) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o              = (state_q != StIdle);
  assign write_hilo_enable_o = (state_q == StDone);
  assign write_hi_data_o     = hi_q;
  assign write_lo_data_o     = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level reference model compared every cycle,
// directed literal cases, then randomized start/cancel/reset traffic.
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
  localparam bit ZFast = 1'b1;
  localparam int ZLat  = 1;
`else
  localparam bit ZFast = 1'b0;
  localparam int ZLat  = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sdiv = 1'b0;
  logic [31:0] dvd = '0;
  logic [31:0] dvs = '0;
  logic        cancel = 1'b0;
  logic        busy, we;
  logic [31:0] hi, lo;

  div_unit dut (
    .clock_i            (clk),
    .reset_i            (rst),
    .start_i            (start),
    .signed_div_i       (sdiv),
    .dividend_i         (dvd),
    .divisor_i          (dvs),
    .cancel_i           (cancel),
    .busy_o             (busy),
    .write_hilo_enable_o(we),
    .write_hi_data_o    (hi),
    .write_lo_data_o    (lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural DIV/DIVU result, including the divide-by-zero convention.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, t;
    if (b == 0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t = sa / sb;
      q = t[31:0];
      t = sa % sb;
      r = t[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Transaction model: an accepted op is in flight for a fixed number of cycles.
  bit          m_act = 1'b0;
  bit          m_we = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    bit          old_we;
    logic [31:0] q, r;
    if (rst) begin
      m_act = 1'b0; m_we = 1'b0; m_left = 0; m_hi = '0; m_lo = '0;
    end else if (cancel) begin
      m_act = 1'b0; m_we = 1'b0;
    end else begin
      old_we = m_we;
      m_we   = 1'b0;
      if (m_act) begin
        m_left--;
        if (m_left == 0) begin
          m_act = 1'b0; m_we = 1'b1; m_hi = p_hi; m_lo = p_lo;
        end
      end else if (!old_we && start) begin
        ref_div(sdiv, dvd, dvs, q, r);
        if (ZFast && dvs == 0) begin
          m_we = 1'b1; m_hi = r; m_lo = q;
        end else begin
          m_act = 1'b1; m_left = 32; p_hi = r; p_lo = q;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check32("busy", {31'd0, busy}, {31'd0, m_act | m_we});
      check32("we", {31'd0, we}, {31'd0, m_we});
      check32("hi", hi, m_hi);
      check32("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string name, input logic s, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_hi,
                    input logic [31:0] exp_lo, input int exp_lat);
    int lat;
    start = 1'b1; sdiv = s; dvd = a; dvs = b;
    tick();
    start = 1'b0;
    lat = 1;
    while (we !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check32({name, "_lat"}, lat, exp_lat);
    check32({name, "_hi"}, hi, exp_hi);
    check32({name, "_lo"}, lo, exp_lo);
    tick();
    check32({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] gen();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses, lat;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_we", {31'd0, we}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);

    op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33);
    op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, ZLat);
    op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, ZLat);

    // Cancel in cycle 10, restart in cycle 11.
    pulses = 0;
    start = 1'b1; sdiv = 1'b0; dvd = 32'd100; dvs = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (we === 1'b1) pulses++;
      tick();
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check32("cancel_busy", {31'd0, busy}, 32'd0);
    check32("cancel_pulses", pulses, 32'd0);
    op("after_cancel", 1'b0, 32'd1000, 32'd9, 32'd1, 32'd111, 33);

    // Start while busy is ignored.
    start = 1'b1; sdiv = 1'b0; dvd = 32'd100; dvs = 32'd7;
    tick();
    start = 1'b0;
    lat = 1;
    while (we !== 1'b1 && lat < 60) begin
      if (lat == 5) begin
        start = 1'b1; sdiv = 1'b1; dvd = 32'd50; dvs = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check32("busy_start_lat", lat, 32'd33);
    check32("busy_start_hi", hi, 32'd2);
    check32("busy_start_lo", lo, 32'd14);
    tick();

    // Reset in cycle 20.
    pulses = 0;
    start = 1'b1; sdiv = 1'b0; dvd = 32'd9; dvs = 32'd4;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("mid_rst_busy", {31'd0, busy}, 32'd0);
    check32("mid_rst_we", {31'd0, we}, 32'd0);
    check32("mid_rst_hi", hi, 32'd0);
    check32("mid_rst_lo", lo, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (we === 1'b1) pulses++;
      tick();
    end
    check32("mid_rst_pulses", pulses, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      start  = ($urandom % 4) == 0;
      sdiv   = $urandom % 2;
      dvd    = gen();
      dvs    = gen();
      cancel = ($urandom % 97) == 0;
      rst    = ($urandom % 1500) == 0;
      tick();
    end
    start = 1'b0; cancel = 1'b0; rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
